// File: rtl/wts_i2s_transmitter.sv
// wts_i2s_transmitter: buffers one offset-binary stereo pair and serialises it as an I2S frame; WTS_I2S_UNDERRUN_MUTE_EN mutes on underrun instead of repeating the last pair
module wts_i2s_transmitter #(
  parameter int DATA_W   = 12,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              overrun,
  output logic              underrun
);
  localparam int BW = $clog2(2*SLOT_W);
  localparam int DW = $clog2(BCLK_DIV+1);
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic [DATA_W-1:0] hold_l, hold_r, frm_l, frm_r, word, sh;
  logic              hold_full, tc, fall, load, sd_nxt;
  int                p;
  function automatic logic [DATA_W-1:0] to_tc(input logic [DATA_W-1:0] x);
    return {~x[DATA_W-1], x[DATA_W-2:0]};
  endfunction
  // bclk edge detection, next bit position and the bit to shift out on the coming fall
  always_comb begin
    tc      = div_cnt == DW'(BCLK_DIV-1);
    fall    = tc && i2s_bclk;
    load    = fall && bit_cnt == BW'(2*SLOT_W-1);
    bit_nxt = (bit_cnt == BW'(2*SLOT_W-1)) ? '0 : bit_cnt + BW'(1);
    p       = (int'(bit_nxt) >= SLOT_W) ? int'(bit_nxt) - SLOT_W : int'(bit_nxt);
    word    = (int'(bit_nxt) >= SLOT_W) ? frm_r : frm_l;
    sh      = word << (p - 1);
    sd_nxt  = (p >= 1 && p <= DATA_W) ? sh[DATA_W-1] : 1'b0;
  end
  // divider, serialiser, holding buffer and frame register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= BW'(2*SLOT_W-1);
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b1;
      i2s_sdata <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      frm_l     <= '0;
      frm_r     <= '0;
    end else begin
      div_cnt   <= tc ? '0 : div_cnt + DW'(1);
      overrun   <= sample_valid && hold_full && !load;
      underrun  <= load && !hold_full && !sample_valid;
      hold_full <= load ? (hold_full && sample_valid) : (hold_full || sample_valid);
      if (tc) i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= bit_nxt >= BW'(SLOT_W);
        i2s_sdata <= sd_nxt;
      end
      if (sample_valid && !(load && !hold_full)) begin
        hold_l <= left_in;
        hold_r <= right_in;
      end
      if (load) begin
        if (hold_full) begin
          frm_l <= to_tc(hold_l);
          frm_r <= to_tc(hold_r);
        end else if (sample_valid) begin
          frm_l <= to_tc(left_in);
          frm_r <= to_tc(right_in);
        end
`ifdef WTS_I2S_UNDERRUN_MUTE_EN
        else begin
          frm_l <= '0;
          frm_r <= '0;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_wts_i2s_transmitter.sv
// tb_wts_i2s_transmitter: randomized scoreboard bench for the I2S transmitter
module tb_wts_i2s_transmitter;
  localparam int DW = 12, SW = 16, BD = 4;
  localparam int FR = 4*SW*BD;
  logic clk = 1'b0, reset, sample_valid;
  logic [DW-1:0] left_in, right_in;
  logic i2s_bclk, i2s_lrclk, i2s_sdata, overrun, underrun;
  int checks = 0, errors = 0, frames = 0;
  int e;
  bit hold_v;
  logic [DW-1:0] hl, hr, cl, cr;
  logic [31:0] q[$];

  wts_i2s_transmitter #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .left_in(left_in), .right_in(right_in),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .overrun(overrun), .underrun(underrun));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] conv(input logic [DW-1:0] x);
    return DW'(x - 12'h800);
  endfunction

  function automatic bit is_load(input int t);
    return t >= 2*BD && (t - 2*BD) % FR == 0;
  endfunction

  task automatic model_reset();
    e = 0; hold_v = 0; hl = '0; hr = '0; cl = '0; cr = '0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " bclk"}, i2s_bclk, 0);
    chk({name, " lrclk"}, i2s_lrclk, 1);
    chk({name, " sdata"}, i2s_sdata, 0);
    chk({name, " overrun"}, overrun, 0);
    chk({name, " underrun"}, underrun, 0);
  endtask

  task automatic step(input bit sv, input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit eo, eu;
    sample_valid = sv; left_in = l; right_in = r;
    @(posedge clk);
    e++;
    eo = 0; eu = 0;
    if (is_load(e)) begin
      if (hold_v) begin
        cl = conv(hl); cr = conv(hr);
        hold_v = sv;
        if (sv) begin hl = l; hr = r; end
      end else if (sv) begin
        cl = conv(l); cr = conv(r);
      end else begin
        eu = 1;
`ifdef WTS_I2S_UNDERRUN_MUTE_EN
        cl = '0; cr = '0;
`endif
      end
      q.push_back({1'b0, cl, 3'b0, 1'b0, cr, 3'b0});
    end else if (sv) begin
      eo = hold_v; hold_v = 1; hl = l; hr = r;
    end
    #1;
    chk("overrun", overrun, eo);
    chk("underrun", underrun, eu);
    chk("bclk", i2s_bclk, (e / BD) % 2);
    chk("lrclk", i2s_lrclk, e < 2*BD ? 1 : ((e - 2*BD) / (2*SW*BD)) % 2);
    @(negedge clk);
    sample_valid = 0;
  endtask

  task automatic idle_until(input int t);
    while (e < t) step(0, '0, '0);
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      bit sv;
      sv = ($urandom_range(0, 199) == 0) || (is_load(e + 1) && $urandom_range(0, 2) == 0);
      step(sv, DW'($urandom), DW'($urandom));
    end
  endtask

  // monitor: reassemble each frame from bits sampled on bclk rises, compare with scoreboard
  logic [31:0] gb = '0, gl = '0, exp_f;
  int pos = 0;
  bit started = 0, pl = 1, pb = 0;
  always @(negedge clk) begin
    if (reset) begin
      started = 0; pos = 0; pl = 1; pb = 0;
    end else begin
      if (i2s_bclk && !pb) begin
        if (!i2s_lrclk && pl) begin started = 1; pos = 0; end
        if (started) begin
          gb = {gb[30:0], i2s_sdata};
          gl = {gl[30:0], i2s_lrclk};
          pos++;
          if (pos == 32) begin
            started = 0; pos = 0; frames++;
            if (q.size() == 0) chk("frame without expectation", int'(gb), -1);
            else begin
              exp_f = q.pop_front();
              chk("frame bits", int'(gb), int'(exp_f));
              chk("frame lrclk", int'(gl), 32'h0000ffff);
            end
          end
        end
        pl = i2s_lrclk;
      end
      pb = i2s_bclk;
    end
  end

  initial begin
    int ld;
    reset = 1; sample_valid = 0; left_in = '0; right_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 0;
    idle_until(1);
    step(1, 12'hfff, 12'h000);
    idle_until(49);
    step(1, 12'h900, 12'h123);
    idle_until(99);
    step(1, 12'ha00, 12'h456);
    idle_until(2*BD + 2*FR - 1);
    step(1, 12'hc00, 12'h789);
    idle_until(599);
    step(1, 12'h900, 12'h0ff);
    idle_until(2*BD + 4*FR + 5);
    rand_run(1500);
    ld = 2*BD + FR * ((e - 2*BD) / FR + 1);
    idle_until(ld + 100);
    step(1, 12'h5a5, 12'ha5a);
    idle_until(ld + 20*2*BD);
    reset = 1;
    #1;
    chk_reset_vals("mid-frame reset");
    q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    idle_until(10);
    rand_run(1100);
    chk("frames seen >= 8", int'(frames >= 8), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
